// File: rtl/uart_cmd_framer_if.sv
// Signal bundle between the UART transceiver, the command framer and the command processor.
// The master modport is the framer side; the slave modport is its environment.
interface uart_cmd_framer_if;
    // Byte handshake: the receiver holds rx_rdy until the framer returns a single clr_rx_rdy pulse.
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic [7:0] cmd;
    logic [15:0] data;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] resp;
    logic       send_resp;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_busy;
    logic       frame_err;
    logic       overrun;
    logic [1:0] dbg_rx_state;
    logic       dbg_tx_state;

    modport master (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, tx_busy,
               frame_err, overrun, dbg_rx_state, dbg_tx_state
    );

    modport slave (
        output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, tx_busy,
               frame_err, overrun, dbg_rx_state, dbg_tx_state
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// Assembles 3-byte UART frames (opcode, data high, data low) into a 24-bit command
// and serialises single-byte responses back to the UART transmitter.
module uart_cmd_framer #(
    parameter int TIMEOUT = 100000
) (
    input logic             clk,
    input logic             rst,
    uart_cmd_framer_if.master bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_HI = 2'd1, RX_LO = 2'd2} rx_state_e;
    typedef enum logic {TX_IDLE = 1'b0, TX_WAIT = 1'b1} tx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [7:0]    op_q, op_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          overrun_q, overrun_d;
    logic          clr_rx_rdy_q, clr_rx_rdy_d;
    logic          frame_err_q, frame_err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          trmt_q, trmt_d;
    logic          tx_busy_q, tx_busy_d;

    logic accept;
    logic complete;
    logic tmo_hit;

    // A byte still being acknowledged must not be taken a second time.
    assign accept  = bus.rx_rdy && !clr_rx_rdy_q;
    assign tmo_hit = (cnt_q == TMO_MAX);

    always_comb begin
        rx_state_d   = rx_state_q;
        op_d         = op_q;
        hi_d         = hi_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        cmd_rdy_d    = cmd_rdy_q;
        overrun_d    = overrun_q;
        clr_rx_rdy_d = accept;
        frame_err_d  = 1'b0;
        cnt_d        = cnt_q;
        complete     = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_d       = bus.rx_data;
                    rx_state_d = RX_HI;
                end
            end
            RX_HI, RX_LO: begin
                if (accept) begin
                    cnt_d = '0;
                    if (rx_state_q == RX_HI) begin
                        hi_d       = bus.rx_data;
                        rx_state_d = RX_LO;
                    end else begin
                        cmd_d      = op_q;
                        data_d     = {hi_q, bus.rx_data};
                        complete   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else if (tmo_hit) begin
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    rx_state_d  = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d      = '0;
                rx_state_d = RX_IDLE;
            end
        endcase

        // A completing frame beats a same-cycle clear; only an unacknowledged overwrite is an overrun.
        if (complete) begin
            cmd_rdy_d = 1'b1;
            if (cmd_rdy_q && !bus.clr_cmd_rdy) begin
                overrun_d = 1'b1;
            end
        end else if (bus.clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        tx_busy_d  = tx_busy_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d  = bus.resp;
                    trmt_d     = 1'b1;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (bus.tx_done) begin
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            op_q         <= '0;
            hi_q         <= '0;
            cmd_q        <= '0;
            data_q       <= '0;
            cmd_rdy_q    <= 1'b0;
            overrun_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cnt_q        <= '0;
            tx_state_q   <= TX_IDLE;
            tx_data_q    <= '0;
            trmt_q       <= 1'b0;
            tx_busy_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            op_q         <= op_d;
            hi_q         <= hi_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            cmd_rdy_q    <= cmd_rdy_d;
            overrun_q    <= overrun_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            frame_err_q  <= frame_err_d;
            cnt_q        <= cnt_d;
            tx_state_q   <= tx_state_d;
            tx_data_q    <= tx_data_d;
            trmt_q       <= trmt_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    assign bus.clr_rx_rdy   = clr_rx_rdy_q;
    assign bus.cmd          = cmd_q;
    assign bus.data         = data_q;
    assign bus.cmd_rdy      = cmd_rdy_q;
    assign bus.overrun      = overrun_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.trmt         = trmt_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.dbg_rx_state = rx_state_q;
    assign bus.dbg_tx_state = tx_state_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: frame assembly, timeout discard, overrun,
// completion/clear collision, response transmit and mid-frame reset.
module tb_uart_cmd_framer;

    localparam int TMO = 16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   clr_cnt  = 0;
    int   fe_cnt   = 0;
    int   tr_cnt   = 0;

    uart_cmd_framer_if bus ();

    uart_cmd_framer #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.clr_rx_rdy === 1'b1) clr_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.trmt === 1'b1) tr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte like the UART receiver: hold rx_rdy until clr_rx_rdy is seen.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic clr_same);
        bit seen;
        seen = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_rdy      = 1'b1;
        bus.rx_data     = b;
        bus.clr_cmd_rdy = clr_same;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            bus.clr_cmd_rdy = 1'b0;
            if (bus.clr_rx_rdy === 1'b1) seen = 1'b1;
        end
        bus.rx_rdy = 1'b0;
        chk("rx_ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0, f0, t0;
        rst             = 1'b1;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp        = 8'h00;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_cmd_data", {8'd0, bus.cmd, bus.data}, 32'd0);
        chk("rst_flags", {27'd0, bus.cmd_rdy, bus.overrun, bus.frame_err, bus.clr_rx_rdy, bus.trmt}, 32'd0);
        chk("rst_tx", {23'd0, bus.tx_busy, bus.tx_data}, 32'd0);
        chk("rst_rx_state", {30'd0, bus.dbg_rx_state}, 32'd0);

        // 1: basic frame 05 FF FF
        c0 = clr_cnt;
        send_byte(8'h05, 1, 1'b0);
        chk("t1_state_hi", {30'd0, bus.dbg_rx_state}, 32'd1);
        send_byte(8'hFF, 3, 1'b0);
        chk("t1_rdy_before", {31'd0, bus.cmd_rdy}, 32'd0);
        send_byte(8'hFF, 5, 1'b0);
        chk("t1_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("t1_cmd_data", {8'd0, bus.cmd, bus.data}, 32'h0005FFFF);
        repeat (3) @(negedge clk);
        chk("t1_clr_pulses", c0 == 0 ? clr_cnt : clr_cnt - c0, 32'd3);
        clear_cmd();
        chk("t1_rdy_cleared", {31'd0, bus.cmd_rdy}, 32'd0);

        // 2: timeout on a partial frame, then a good frame
        f0 = fe_cnt;
        send_byte(8'h06, 1, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        chk("t2_no_err_early", {31'd0, bus.frame_err}, 32'd0);
        @(negedge clk);
        chk("t2_err_pulse", {31'd0, bus.frame_err}, 32'd1);
        chk("t2_hold_cmd_data", {8'd0, bus.cmd, bus.data}, 32'h0005FFFF);
        @(negedge clk);
        chk("t2_err_gone", {31'd0, bus.frame_err}, 32'd0);
        chk("t2_state_idle", {30'd0, bus.dbg_rx_state}, 32'd0);
        send_byte(8'h01, 2, 1'b0);
        send_byte(8'h00, 1, 1'b0);
        chk("t2_rdy_before", {31'd0, bus.cmd_rdy}, 32'd0);
        send_byte(8'h00, 1, 1'b0);
        chk("t2_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("t2_cmd_data", {8'd0, bus.cmd, bus.data}, 32'h00010000);
        @(negedge clk);
        chk("t2_err_count", fe_cnt - f0, 32'd1);

        // 3: overrun on an unacknowledged frame, cleared only by reset
        clear_cmd();
        send_byte(8'h02, 1, 1'b0);
        send_byte(8'h12, 1, 1'b0);
        send_byte(8'h34, 1, 1'b0);
        chk("t3_first", {7'd0, bus.overrun, bus.cmd, bus.data}, 32'h00021234);
        send_byte(8'h03, 2, 1'b0);
        send_byte(8'hAB, 1, 1'b0);
        send_byte(8'hCD, 1, 1'b0);
        chk("t3_overrun", {7'd0, bus.overrun, bus.cmd, bus.data}, 32'h0103ABCD);
        clear_cmd();
        chk("t3_overrun_sticky", {30'd0, bus.overrun, bus.cmd_rdy}, 32'd2);
        pulse_rst();
        chk("t3_after_rst", {30'd0, bus.overrun, bus.cmd_rdy}, 32'd0);

        // 4: completion coinciding with clr_cmd_rdy
        send_byte(8'h44, 1, 1'b0);
        send_byte(8'h55, 1, 1'b0);
        send_byte(8'h66, 1, 1'b0);
        send_byte(8'h77, 1, 1'b0);
        send_byte(8'h88, 1, 1'b0);
        send_byte(8'h99, 1, 1'b1);
        chk("t4_rdy_ovr", {30'd0, bus.cmd_rdy, bus.overrun}, 32'd2);
        chk("t4_cmd_data", {8'd0, bus.cmd, bus.data}, 32'h00778899);
        clear_cmd();
        chk("t4_cleared", {31'd0, bus.cmd_rdy}, 32'd0);

        // 5: response transmit
        t0 = tr_cnt;
        @(negedge clk);
        bus.resp      = 8'hA5;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        chk("t5_start", {22'd0, bus.trmt, bus.tx_busy, bus.tx_data}, 32'h000003A5);
        @(negedge clk);
        chk("t5_trmt_single", {31'd0, bus.trmt}, 32'd0);
        bus.resp      = 8'h33;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        chk("t5_busy_ignore", {23'd0, bus.tx_busy, bus.tx_data}, 32'h000001A5);
        @(negedge clk);
        bus.resp      = 8'h77;
        bus.send_resp = 1'b1;
        bus.tx_done   = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        bus.tx_done   = 1'b0;
        chk("t5_done_ignore", {23'd0, bus.tx_busy, bus.tx_data}, 32'h000000A5);
        @(negedge clk);
        chk("t5_trmt_count", tr_cnt - t0, 32'd1);
        bus.resp      = 8'h5A;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        chk("t5_resend", {22'd0, bus.trmt, bus.tx_busy, bus.tx_data}, 32'h0000035A);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        chk("t5_idle", {31'd0, bus.tx_busy}, 32'd0);

        // 6: reset after two bytes drops the partial frame
        f0 = fe_cnt;
        send_byte(8'h11, 1, 1'b0);
        send_byte(8'h22, 1, 1'b0);
        pulse_rst();
        send_byte(8'h08, 1, 1'b0);
        send_byte(8'h00, 1, 1'b0);
        send_byte(8'h13, 1, 1'b0);
        chk("t6_cmd_data", {7'd0, bus.cmd_rdy, bus.cmd, bus.data}, 32'h01080013);
        repeat (TMO + 4) @(negedge clk);
        chk("t6_no_err", fe_cnt - f0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
